// File: rtl/csa_accum_ctrl.sv
// ---------------------------------------------------------------------------
// csa_accum_ctrl
//
// Sequencing controller for a multi-operand accumulator. The running total
// is kept in redundant sum/carry form using a 3:2 carry-save compressor, so
// accepting an operand never waits for a carry chain. When the last operand
// of a transaction arrives, the sum/carry pair is resolved with a chunked
// carry-propagate add, RES_CHUNK bits per cycle. The result is then held on
// the output handshake until the consumer takes it.
//
// Parameters:
//   WIDTH      operand / accumulator / result width (results wrap)
//   RES_CHUNK  bits resolved per cycle; WIDTH must be a multiple of it
//   CNT_W      width of the saturating operand counter
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   abort      (only with CSA_ACCUM_ABORT_EN) drop the current transaction
//   in_valid   operand valid
//   in_ready   controller can accept an operand
//   in_data    operand
//   in_last    final operand of the transaction (qualified by in_valid)
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_data   resolved sum (0 outside DONE)
//   out_count  operands accepted, saturating (0 outside DONE)
//   busy       high whenever the controller is not IDLE
//
// Optional feature macro: CSA_ACCUM_ABORT_EN (adds the abort input).
// ---------------------------------------------------------------------------
module csa_accum_ctrl #(
    parameter int WIDTH     = 32,
    parameter int RES_CHUNK = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
`ifdef CSA_ACCUM_ABORT_EN
    input  logic             abort,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    localparam int CHUNKS = WIDTH / RES_CHUNK;
    localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    if (RES_CHUNK <= 0 || (WIDTH % RES_CHUNK) != 0) begin : g_bad_chunk
        $fatal(1, "csa_accum_ctrl: WIDTH must be a positive multiple of RES_CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        RESOLVE,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   s;
    logic [WIDTH-1:0]   c;
    logic [WIDTH-1:0]   result;
    logic [CNT_W-1:0]   count;
    logic [IDX_W-1:0]   chunk_idx;
    logic               carry;

    logic [WIDTH-1:0]   s_next;
    logic [WIDTH-1:0]   c_next;
    logic [CNT_W-1:0]   count_next;
    logic [WIDTH-1:0]   result_next;
    logic [RES_CHUNK:0] chunk_sum;
    logic               abort_req;
    logic               clear;
    logic               accept;
    logic               last_chunk;

`ifdef CSA_ACCUM_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Reset and abort both wipe the whole controller; reset simply wins by
    // being OR-ed into the same clear path.
    assign clear = rst | abort_req;

    // in_ready follows the state directly, gated by rst so it is already low
    // during reset before any clock edge has been seen.
    assign in_ready = ((state == IDLE) || (state == ACCUM)) && !rst;

    // An abort in IDLE leaves in_ready high but the operand must not be taken.
    assign accept     = in_valid && in_ready && !abort_req;
    assign last_chunk = (chunk_idx == IDX_W'(CHUNKS - 1));

    // Carry-save step, saturating counter and one chunk of the final
    // carry-propagate add. The chunk carry-out lands in chunk_sum's MSB.
    always_comb begin
        s_next      = s ^ c ^ in_data;
        c_next      = ((s & c) | (s & in_data) | (c & in_data)) << 1;
        count_next  = (count == '1) ? count : count + CNT_W'(1);
        chunk_sum   = {1'b0, s[chunk_idx*RES_CHUNK +: RES_CHUNK]}
                    + {1'b0, c[chunk_idx*RES_CHUNK +: RES_CHUNK]}
                    + (RES_CHUNK+1)'(carry);
        result_next = result;
        result_next[chunk_idx*RES_CHUNK +: RES_CHUNK] = chunk_sum[RES_CHUNK-1:0];
    end

    // Controller FSM. out_valid/out_data/out_count/busy are registered so the
    // result is loaded in the same edge that completes the final chunk.
    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= IDLE;
            s         <= '0;
            c         <= '0;
            result    <= '0;
            count     <= '0;
            chunk_idx <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        s     <= s_next;
                        c     <= c_next;
                        count <= count_next;
                        busy  <= 1'b1;
                        state <= in_last ? RESOLVE : ACCUM;
                    end
                end
                RESOLVE: begin
                    result <= result_next;
                    if (last_chunk) begin
                        chunk_idx <= '0;
                        carry     <= 1'b0;
                        out_valid <= 1'b1;
                        out_data  <= result_next;
                        out_count <= count;
                        state     <= DONE;
                    end else begin
                        chunk_idx <= chunk_idx + IDX_W'(1);
                        carry     <= chunk_sum[RES_CHUNK];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        s         <= '0;
                        c         <= '0;
                        result    <= '0;
                        count     <= '0;
                        carry     <= 1'b0;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        out_count <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csa_accum_ctrl
//
// Self-checking bench for csa_accum_ctrl with default parameters. Expected
// results are pushed to a scoreboard queue when the last operand of a
// transaction is accepted and compared by a monitor while out_valid is high.
// Build with +define+CSA_ACCUM_ABORT_EN to also exercise the abort input.
// ---------------------------------------------------------------------------
module tb_csa_accum_ctrl;

    localparam int WIDTH   = 32;
    localparam int CNT_W   = 16;
    localparam int LATENCY = 4;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [CNT_W-1:0] count;
    } exp_t;

    typedef struct {
        string                  name;
        int                     n;
        logic [2:0][WIDTH-1:0]  ops;
        logic [WIDTH-1:0]       exp_data;
        logic [CNT_W-1:0]       exp_count;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             busy;
`ifdef CSA_ACCUM_ABORT_EN
    logic             abort;
`endif

    int   checks;
    int   errors;
    int   cycle_cnt;
    int   last_accept_cycle;
    int   stall_total;
    logic prev_valid;
    exp_t sb[$];
    vec_t vecs[6];

    csa_accum_ctrl dut (
        .clk       (clk),
        .rst       (rst),
`ifdef CSA_ACCUM_ABORT_EN
        .abort     (abort),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .busy      (busy)
    );

    // 10-time-unit clock plus a free-running cycle counter for latency checks.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Single comparison point: every check goes through here.
    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drive one operand and hold it until accepted (bounded). On the last
    // operand the expected result is pushed to the scoreboard.
    task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic last,
                                 input logic [WIDTH-1:0] exp_d,
                                 input logic [CNT_W-1:0] exp_c);
        exp_t e;
        bit   taken;
        taken    = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int w = 0; w < 50 && !taken; w++) begin
            if (in_ready) taken = 1'b1;
            else          stall_total = stall_total + 1;
            @(posedge clk);
            #1;
        end
        if (!taken) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL accept_timeout: operand 0x%08h not accepted, expected accept within 50 cycles", d);
        end else if (last) begin
            e.data  = exp_d;
            e.count = exp_c;
            sb.push_back(e);
            last_accept_cycle = cycle_cnt;
        end
    endtask

    task automatic waitIdle(input string name);
        bit done;
        done = 1'b0;
        for (int w = 0; w < 200 && !done; w++) begin
            if (sb.size() == 0 && !busy) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL %s_timeout: still busy with %0d pending, expected idle within 200 cycles",
                     name, sb.size());
        end
    endtask

    // Monitor on the falling edge: compare the held result against the
    // scoreboard every DONE cycle, pop when the handshake will complete, and
    // check the outputs are zeroed whenever no result is presented.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid) begin
                if (!prev_valid)
                    checkOutput("latency", WIDTH'(cycle_cnt - last_accept_cycle), WIDTH'(LATENCY));
                if (sb.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("[TB] FAIL unexpected_out_valid: out_data 0x%08h, expected no result", out_data);
                end else begin
                    checkOutput("out_data", out_data, sb[0].data);
                    checkOutput("out_count", WIDTH'(out_count), WIDTH'(sb[0].count));
                    checkOutput("in_ready_in_done", WIDTH'(in_ready), 0);
                    checkOutput("busy_in_done", WIDTH'(busy), 1);
                    if (out_ready) void'(sb.pop_front());
                end
            end else begin
                checkOutput("out_data_idle_zero", out_data, 0);
                checkOutput("out_count_idle_zero", WIDTH'(out_count), 0);
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        logic [WIDTH-1:0] model_sum;
        bit               seen;

        checks            = 0;
        errors            = 0;
        stall_total       = 0;
        last_accept_cycle = 0;
        prev_valid        = 1'b0;
        rst               = 1'b1;
        in_valid          = 1'b0;
        in_data           = '0;
        in_last           = 1'b0;
        out_ready         = 1'b1;
`ifdef CSA_ACCUM_ABORT_EN
        abort             = 1'b0;
`endif

        vecs[0] = '{"sum_5_7_9",   3, {32'd9, 32'd7, 32'd5},                      32'd21,         16'd3};
        vecs[1] = '{"wrap_carry",  2, {32'd0, 32'h0000_0002, 32'hFFFF_FFFF},      32'h0000_0001, 16'd2};
        vecs[2] = '{"single_a5",   1, {32'd0, 32'd0, 32'hA5A5_A5A5},              32'hA5A5_A5A5, 16'd1};
        vecs[3] = '{"msb_pair",    3, {32'h1, 32'h8000_0000, 32'h8000_0000},      32'h0000_0001, 16'd3};
        vecs[4] = '{"chunk_wrap",  3, {32'hFF00_0000, 32'h00FF_0001, 32'h0000_FFFF}, 32'h0000_0000, 16'd3};
        vecs[5] = '{"max_pos",     2, {32'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF},      32'hFFFF_FFFE, 16'd2};

        // Reset values, before and after reset edges.
        #1;
        checkOutput("in_ready_during_rst", WIDTH'(in_ready), 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", WIDTH'(out_valid), 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_count", WIDTH'(out_count), 0);
        checkOutput("rst_busy", WIDTH'(busy), 0);
        checkOutput("rst_in_ready", WIDTH'(in_ready), 0);
        rst = 1'b0;
        #1;
        checkOutput("in_ready_after_rst", WIDTH'(in_ready), 1);

        // Table-driven transactions.
        for (int i = 0; i < 6; i++) begin
            $display("[TB] vector %s", vecs[i].name);
            for (int k = 0; k < vecs[i].n; k++)
                applyStimulus(vecs[i].ops[k], k == vecs[i].n - 1, vecs[i].exp_data, vecs[i].exp_count);
            in_valid = 1'b0;
            in_last  = 1'b0;
            waitIdle(vecs[i].name);
            checkOutput("in_ready_after_txn", WIDTH'(in_ready), 1);
        end

        // Stream 1..100 back-to-back; no cycle may be lost waiting for in_ready.
        $display("[TB] streaming 1..100");
        model_sum   = '0;
        for (int i = 1; i <= 100; i++) model_sum = model_sum + WIDTH'(i);
        stall_total = 0;
        for (int i = 1; i <= 100; i++)
            applyStimulus(WIDTH'(i), i == 100, model_sum, 16'd100);
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkOutput("stream_stalls", WIDTH'(stall_total), 0);
        waitIdle("stream");

        // Back-pressure: result must be held for 10 cycles, then handshake.
        $display("[TB] output back-pressure");
        out_ready = 1'b0;
        applyStimulus(32'd11, 1'b0, 32'd0, 16'd0);
        applyStimulus(32'd22, 1'b1, 32'd33, 16'd2);
        in_valid = 1'b0;
        in_last  = 1'b0;
        seen     = 1'b0;
        for (int w = 0; w < 20 && !seen; w++) begin
            if (out_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        checkOutput("stall_out_valid_rise", WIDTH'(seen), 1);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("stall_out_valid_held", WIDTH'(out_valid), 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("stall_released_valid", WIDTH'(out_valid), 0);
        checkOutput("stall_released_busy", WIDTH'(busy), 0);
        checkOutput("stall_released_ready", WIDTH'(in_ready), 1);

        // Reset in the second RESOLVE cycle: transaction is dropped silently.
        $display("[TB] reset during resolve");
        applyStimulus(32'd10, 1'b0, 32'd0, 16'd0);
        applyStimulus(32'd20, 1'b1, 32'd30, 16'd2);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_busy", WIDTH'(busy), 0);
        checkOutput("rst_mid_in_ready", WIDTH'(in_ready), 1);
        repeat (8) @(posedge clk);
        #1;
        applyStimulus(32'd3, 1'b0, 32'd0, 16'd0);
        applyStimulus(32'd4, 1'b1, 32'd7, 16'd2);
        in_valid = 1'b0;
        in_last  = 1'b0;
        waitIdle("after_rst");

`ifdef CSA_ACCUM_ABORT_EN
        // Same drop sequence using abort instead of reset.
        $display("[TB] abort during resolve");
        applyStimulus(32'd10, 1'b0, 32'd0, 16'd0);
        applyStimulus(32'd20, 1'b1, 32'd30, 16'd2);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        abort = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("abort_mid_busy", WIDTH'(busy), 0);
        checkOutput("abort_mid_in_ready", WIDTH'(in_ready), 1);
        repeat (8) @(posedge clk);
        #1;
        applyStimulus(32'd3, 1'b0, 32'd0, 16'd0);
        applyStimulus(32'd4, 1'b1, 32'd7, 16'd2);
        in_valid = 1'b0;
        in_last  = 1'b0;
        waitIdle("after_abort");

        // Abort in IDLE beats an offered operand.
        in_valid = 1'b1;
        in_data  = 32'd99;
        in_last  = 1'b1;
        abort    = 1'b1;
        #1;
        checkOutput("abort_idle_in_ready", WIDTH'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        abort    = 1'b0;
        checkOutput("abort_idle_not_taken", WIDTH'(busy), 0);
        repeat (6) @(posedge clk);
        #1;
`endif

        waitIdle("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csa_accum_ctrl.md
Name: csa_accum_ctrl

Overview:
Sequencing controller for a multi-operand accumulator built on the team's 3:2 carry-save compressor.
- Accepts a stream of operands at one per cycle over a valid/ready handshake.
- Keeps the running total in redundant sum/carry form, so no carry propagates during accumulation.
- On the last operand it resolves the redundant pair with a chunked multi-cycle carry-propagate add and presents the result on an output handshake.
- Intended for dot-product, checksum and multiply partial-product reduction paths.

Parameters:
- WIDTH, 32, operand, accumulator and result width in bits; results wrap modulo 2^WIDTH.
- RES_CHUNK, 8, bits resolved per cycle in RESOLVE; WIDTH must be a multiple of RES_CHUNK (elaboration-time check, fatal otherwise).
- CNT_W, 16, width of the operand counter.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  controller can accept an operand.
- in_data  input  WIDTH  operand.
- in_last  input  1  marks the final operand of a transaction; qualified by in_valid.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  resolved sum.
- out_count  output  CNT_W  number of operands accepted in the transaction; saturates at 2^CNT_W-1.
- busy  output  1  high in ACCUM, RESOLVE and DONE.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset state: state=IDLE, internal S=0, C=0, result=0, count=0, chunk index=0, carry bit=0.
- Reset output values: in_ready=0 while rst is high; out_valid=0, out_data=0, out_count=0, busy=0.
- Reset mid-operation discards everything, with no output.
- Accept: an operand is accepted on a clock edge where in_valid && in_ready.
- State IDLE: in_ready=1; S and C are held at 0. Accept with in_last=0 goes to ACCUM; accept with in_last=1 goes to RESOLVE.
- State ACCUM: in_ready=1; stays until an operand with in_last=1 is accepted, then goes to RESOLVE. No accept means hold.
- Per accepted operand d (all bitwise, truncated to WIDTH):
  - S' = S^C^d
  - C' = ((S&C)|(S&d)|(C&d)) << 1, with bit 0 = 0 and the MSB carry dropped
  - count' = sat(count+1)
- Sustained throughput is one operand per cycle with no bubbles.
- State RESOLVE: in_ready=0. K = WIDTH/RES_CHUNK cycles.
  - Cycle j adds chunk j of S, chunk j of C and the carry bit into result[j*RES_CHUNK +: RES_CHUNK].
  - The chunk carry-out is registered as the carry bit for chunk j+1.
  - Carry out of chunk K-1 is dropped.
  - After chunk K-1 the controller goes to DONE.
- Latency: out_valid rises exactly K cycles after the edge that accepted the last operand (4 with the defaults).
- State DONE: out_valid=1. out_data=result and out_count=count, both stable until the handshake.
  - On out_valid && out_ready: go to IDLE, clear S, C, count and carry bit. in_ready=1 the following cycle.
  - out_ready low holds the controller indefinitely.
- out_data and out_count read 0 outside DONE.
- busy = (state != IDLE).
- in_last with in_valid low is ignored. in_valid is ignored when in_ready=0; the upstream source must hold it.

Optional Feature:
- Macro: CSA_ACCUM_ABORT_EN.
- Enabled: adds input port abort (1 bit).
  - abort high on any edge in ACCUM, RESOLVE or DONE returns to IDLE with all state cleared, as for reset. out_valid never rises for that transaction.
  - In IDLE, abort has priority over an accept: the operand is not taken and in_ready stays 1.
  - Reset has priority over abort.
- Disabled: the port is absent; a transaction always completes.

Test Plan:
- Operands 5, 7, 9 (last on 9) back-to-back, out_ready=1 -> out_valid 4 cycles after the last accept; out_data=21, out_count=3, then in_ready=1.
- Operands 1..100 streamed with in_valid held high -> no in_ready bubbles during ACCUM; out_data=5050, out_count=100.
- Operands 0xFFFFFFFF then 0x00000002 (last) -> out_data=0x00000001, confirming wrap and a carry crossing all chunk boundaries.
- Single operand 0xA5A5A5A5 with in_last=1 from IDLE -> out_data=0xA5A5A5A5, out_count=1.
- out_ready low for 10 cycles in DONE -> out_valid, out_data and out_count stable, in_ready=0; handshake on cycle 11, then IDLE.
- rst pulsed in cycle 2 of RESOLVE -> no out_valid; next transaction 3, 4 (last) gives 7, count 2. With CSA_ACCUM_ABORT_EN, the same check is repeated with abort instead of rst.
